// File: rtl/signext_reg.sv
// LEGv8 decode-stage immediate extractor.
// Registers the extended immediate one cycle after the instruction.
module signext_reg (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic        out_valid,
    output logic [63:0] result,
    output logic [1:0]  imm_kind,
    output logic        illegal
);

    logic        is_cb;
    logic        is_mem;
    logic        is_addi;
    logic [63:0] next_result;
    logic [1:0]  next_kind;
    logic        next_illegal;

    assign is_cb   = instruction[31:25] == 7'b1011010;
    assign is_mem  = (instruction[31:21] == 11'b11111000010) ||
                     (instruction[31:21] == 11'b11111000000);
    assign is_addi = instruction[31:22] == 10'b1001000100;

    // Decode the opcode prefix and extend the matching immediate field
    always_comb begin
        next_result  = 64'd0;
        next_kind    = 2'd0;
        next_illegal = 1'b0;
        unique case (1'b1)
            is_cb: begin
                next_result = {{45{instruction[23]}}, instruction[23:5]};
                next_kind   = 2'd1;
            end
            is_mem: begin
                next_result = {{55{instruction[20]}}, instruction[20:12]};
                next_kind   = 2'd2;
            end
            is_addi: begin
                next_result = {52'd0, instruction[21:10]};
                next_kind   = 2'd3;
            end
            default: begin
                next_illegal = 1'b1;
            end
        endcase
    end

    // Capture the decode on valid cycles; hold the payload otherwise
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= 64'd0;
            imm_kind  <= 2'd0;
            illegal   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= next_result;
                imm_kind <= next_kind;
                illegal  <= next_illegal;
            end
        end
    end

endmodule

// File: tb/tb_signext_reg.sv
// Directed bench for signext_reg.
// Inputs change on the falling edge; outputs sampled 1 ns after the rising edge.
module tb_signext_reg;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [31:0] instruction;
    logic        out_valid;
    logic [63:0] result;
    logic [1:0]  imm_kind;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    signext_reg dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .instruction(instruction),
        .out_valid  (out_valid),
        .result     (result),
        .imm_kind   (imm_kind),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input string tag, input logic [31:0] ins,
                        input logic [63:0] exp_res, input logic [1:0] exp_kind,
                        input logic exp_ill);
        @(negedge clk);
        in_valid    = 1'b1;
        instruction = ins;
        @(posedge clk);
        #1;
        check({tag, ".valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, ".result"}, result, exp_res);
        check({tag, ".kind"}, {62'd0, imm_kind}, {62'd0, exp_kind});
        check({tag, ".illegal"}, {63'd0, illegal}, {63'd0, exp_ill});
    endtask

    localparam logic [63:0] NEG23 = 64'hFFFF_FFFF_FFFF_FFE9;

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b1;
        instruction = $urandom;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            instruction = $urandom;
            @(posedge clk);
            #1;
            check("rst.valid", {63'd0, out_valid}, 64'd0);
            check("rst.result", result, 64'd0);
            check("rst.kind", {62'd0, imm_kind}, 64'd0);
            check("rst.illegal", {63'd0, illegal}, 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        send("cbz_pos", {8'b10110100, 19'd23, 5'd1}, 64'd23, 2'd1, 1'b0);
        send("cbz_neg", {8'b10110100, 19'b1111111111111101001, 5'd1},
             NEG23, 2'd1, 1'b0);
        send("cbnz_pos", {8'b10110101, 19'd23, 5'd1}, 64'd23, 2'd1, 1'b0);
        send("cbnz_neg", {8'b10110101, 19'b1111111111111101001, 5'd7},
             NEG23, 2'd1, 1'b0);
        send("cb_all1", {8'b10110100, 19'h7FFFF, 5'd31},
             64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0);
        send("cb_min", {8'b10110101, 19'h40000, 5'd0},
             64'hFFFF_FFFF_FFFC_0000, 2'd1, 1'b0);
        send("cb_max", {8'b10110100, 19'h3FFFF, 5'd31},
             64'h0000_0000_0003_FFFF, 2'd1, 1'b0);

        send("ldur_pos", {11'b11111000010, 9'd23, 12'd1}, 64'd23, 2'd2, 1'b0);
        send("ldur_neg", {11'b11111000010, 9'b111101001, 12'd1},
             NEG23, 2'd2, 1'b0);
        send("stur_pos", {11'b11111000000, 9'd23, 12'd1}, 64'd23, 2'd2, 1'b0);
        send("stur_neg", {11'b11111000000, 9'b111101001, 12'hFFF},
             NEG23, 2'd2, 1'b0);
        send("ldur_min", {11'b11111000010, 9'h100, 12'd0},
             64'hFFFF_FFFF_FFFF_FF00, 2'd2, 1'b0);

        send("addi_23", {10'b1001000100, 12'd23, 5'd1, 5'd1},
             64'd23, 2'd3, 1'b0);
        send("addi_fff", {10'b1001000100, 12'hFFF, 5'd1, 5'd1},
             64'h0000_0000_0000_0FFF, 2'd3, 1'b0);

        send("illegal", {11'b10011000000, 9'd23, 12'd1}, 64'd0, 2'd0, 1'b1);
        send("illegal0", 32'h0000_0000, 64'd0, 2'd0, 1'b1);

        send("s_cbz", {8'b10110100, 19'b1111111111111101001, 5'd1},
             NEG23, 2'd1, 1'b0);
        send("s_ldur", {11'b11111000010, 9'd23, 12'd1}, 64'd23, 2'd2, 1'b0);
        send("s_addi", {10'b1001000100, 12'd23, 5'd1, 5'd1},
             64'd23, 2'd3, 1'b0);

        @(negedge clk);
        in_valid    = 1'b0;
        instruction = {8'b10110100, 19'h7FFFF, 5'd0};
        @(posedge clk);
        #1;
        check("hold.valid", {63'd0, out_valid}, 64'd0);
        check("hold.result", result, 64'd23);
        check("hold.kind", {62'd0, imm_kind}, 64'd3);
        check("hold.illegal", {63'd0, illegal}, 64'd0);
        @(posedge clk);
        #1;
        check("hold2.result", result, 64'd23);

        @(negedge clk);
        reset_n     = 1'b0;
        in_valid    = 1'b1;
        instruction = {8'b10110100, 19'd5, 5'd0};
        @(posedge clk);
        #1;
        check("rstwin.valid", {63'd0, out_valid}, 64'd0);
        check("rstwin.result", result, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
